// File: rtl/uart_core.sv
// ============================================================================
// Module   : uart_core
// Brief    : Parametrised UART transceiver with RX FIFO, per-word error flags
//            and internal loopback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_core #(
    parameter int MHZ       = 50,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rxd,
    output logic                       txd,
    input  logic                       loopback,
    input  logic                       tx_vld,
    input  logic [DATA_BITS-1:0]       tx_data,
    output logic                       tx_rdy,
    input  logic                       rx_rd,
    output logic [DATA_BITS-1:0]       rx_data,
    output logic                       rx_perr,
    output logic                       rx_ferr,
    output logic                       rx_empty,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic                       rx_overflow
);

    localparam int c_CLKS = MHZ * 1000000 / BAUD;
    localparam int c_CW   = $clog2(c_CLKS);
    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_WW   = DATA_BITS + 2;

    localparam logic [c_CW-1:0] c_BIT_END  = c_CW'(c_CLKS - 1);
    localparam logic [c_CW-1:0] c_HALF_END = c_CW'(c_CLKS / 2 - 1);
    localparam logic [2:0]      c_LAST_DAT = 3'(DATA_BITS - 1);
    localparam logic [2:0]      c_LAST_STP = 3'(STOP_BITS - 1);
    localparam logic            c_ODD      = (PARITY == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // ---------------- transmitter ----------------
    logic [2:0]           r_tx_state;
    logic [c_CW-1:0]      r_tx_cnt;
    logic [2:0]           r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_line;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else if (r_tx_state == S_IDLE) begin
            if (tx_vld) begin
                r_tx_state <= S_START;
                r_tx_line  <= 1'b0;
                r_tx_cnt   <= '0;
                r_tx_shift <= tx_data;
                r_tx_par   <= (^tx_data) ^ c_ODD;
            end
        end else if (r_tx_cnt != c_BIT_END) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end else begin
            r_tx_cnt <= '0;
            case (r_tx_state)
                S_START: begin
                    r_tx_state <= S_DATA;
                    r_tx_idx   <= '0;
                    r_tx_line  <= r_tx_shift[0];
                end
                S_DATA: begin
                    r_tx_shift <= r_tx_shift >> 1;
                    if (r_tx_idx == c_LAST_DAT) begin
                        r_tx_idx <= '0;
                        if (PARITY != 0) begin
                            r_tx_state <= S_PARITY;
                            r_tx_line  <= r_tx_par;
                        end else begin
                            r_tx_state <= S_STOP;
                            r_tx_line  <= 1'b1;
                        end
                    end else begin
                        r_tx_idx  <= r_tx_idx + 1'b1;
                        r_tx_line <= r_tx_shift[1];
                    end
                end
                S_PARITY: begin
                    r_tx_state <= S_STOP;
                    r_tx_line  <= 1'b1;
                end
                default: begin
                    if (r_tx_idx == c_LAST_STP) r_tx_state <= S_IDLE;
                    else                        r_tx_idx   <= r_tx_idx + 1'b1;
                end
            endcase
        end
    end

    assign tx_rdy = (r_tx_state == S_IDLE);
    assign txd    = loopback | r_tx_line;

    // ---------------- receiver ----------------
    logic                 w_rx_src;
    logic                 r_s1, r_s2, r_s3;
    logic [2:0]           r_rx_state;
    logic [c_CW-1:0]      r_rx_cnt;
    logic [2:0]           r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic                 w_push;
    logic                 w_perr;

    assign w_rx_src = loopback ? r_tx_line : rxd;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= w_rx_src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (r_s3 && !r_s2) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == c_HALF_END) begin
                        r_rx_cnt   <= '0;
                        r_rx_idx   <= '0;
                        r_rx_state <= r_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA, S_PARITY, S_STOP: begin
                    if (r_rx_cnt == c_BIT_END) begin
                        r_rx_cnt <= '0;
                        if (r_rx_state == S_DATA) begin
                            // LSB arrives first, so shift in from the top
                            r_rx_shift <= {r_s2, r_rx_shift[DATA_BITS-1:1]};
                            if (r_rx_idx == c_LAST_DAT)
                                r_rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                            else
                                r_rx_idx <= r_rx_idx + 1'b1;
                        end else if (r_rx_state == S_PARITY) begin
                            r_rx_par   <= r_s2;
                            r_rx_state <= S_STOP;
                        end else begin
                            r_rx_state <= r_s2 ? S_IDLE : S_BREAK;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_s2) r_rx_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_push = (r_rx_state == S_STOP) && (r_rx_cnt == c_BIT_END);
    assign w_perr = (PARITY != 0) ? ((^r_rx_shift) ^ r_rx_par ^ c_ODD) : 1'b0;

    // ---------------- receive FIFO ----------------
    logic [c_WW-1:0] r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_ovf;
    logic            w_full, w_empty, w_pop, w_wr;
    logic [c_WW-1:0] w_head;

    assign w_full  = (r_count == (c_AW + 1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = rx_rd & ~w_empty;
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= {w_perr, ~r_s2, r_rx_shift};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Gate the head so outputs read 0 while empty (memory is not reset)
    assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rx_data     = w_head[DATA_BITS-1:0];
    assign rx_ferr     = w_head[DATA_BITS];
    assign rx_perr     = w_head[DATA_BITS+1];
    assign rx_empty    = w_empty;
    assign rx_count    = r_count;
    assign rx_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
// ============================================================================
// Module   : tb_uart_core
// Brief    : Randomised scoreboard bench for uart_core (even parity, 2 stop).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_core;

    localparam int MHZ   = 1;
    localparam int BAUD  = 100000;
    localparam int DB    = 8;
    localparam int PAR   = 2;
    localparam int SB    = 2;
    localparam int DEPTH = 4;
    localparam int CLKS  = MHZ * 1000000 / BAUD;
    localparam int NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd_drv = 1'b1;
    logic       ext_loop = 1'b0;
    logic       loopback = 1'b0;
    logic       tx_vld = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       man_rd = 1'b0;
    logic       mon_rd = 1'b0;
    logic       auto_drain = 1'b1;

    logic       rxd, txd, tx_rdy, rx_rd, rx_perr, rx_ferr, rx_empty, rx_overflow;
    logic [7:0] rx_data;
    logic [2:0] rx_count;

    assign rxd   = ext_loop ? txd : rxd_drv;
    assign rx_rd = man_rd | mon_rd;

    always #5 clk = ~clk;

    uart_core #(
        .MHZ(MHZ), .BAUD(BAUD), .DATA_BITS(DB), .PARITY(PAR),
        .STOP_BITS(SB), .DEPTH(DEPTH)
    ) dut (
        .clock(clk), .reset(rst_n), .rxd(rxd), .txd(txd), .loopback(loopback),
        .tx_vld(tx_vld), .tx_data(tx_data), .tx_rdy(tx_rdy), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_empty(rx_empty), .rx_count(rx_count), .rx_overflow(rx_overflow)
    );

    int         n_vec = 0;
    int         n_fail = 0;
    logic [9:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference FIFO: a word arriving at a full FIFO is lost and flags overflow
    function automatic void model_push(input logic [9:0] w);
        if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
        else                       exp_q.push_back(w);
    endfunction

    function automatic logic par_bit(input logic [7:0] d);
        return (^d) ^ (PAR == 1);
    endfunction

    // Monitor: drains the FIFO and compares every delivered word
    initial begin
        forever begin
            @(negedge clk);
            mon_rd = 1'b0;
            if (auto_drain && rst_n && !rx_empty && !man_rd) begin
                if (exp_q.size() == 0)
                    check("unexpected_word", {22'd0, rx_perr, rx_ferr, rx_data}, 32'h400);
                else
                    check("rx_word", {22'd0, rx_perr, rx_ferr, rx_data}, {22'd0, exp_q.pop_front()});
                mon_rd = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_txd", txd, 1);
        check("rst_tx_rdy", tx_rdy, 1);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_rx_count", rx_count, 0);
        check("rst_overflow", rx_overflow, 0);
        check("rst_rx_data", {rx_perr, rx_ferr, rx_data}, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input bit expect_rx);
        int t = 0;
        while (!tx_rdy && t < 500) begin
            tick(1);
            t++;
        end
        if (!tx_rdy) check("tx_rdy_timeout", tx_rdy, 1);
        tx_data = d;
        tx_vld  = 1'b1;
        tick(1);
        tx_vld  = 1'b0;
        if (expect_rx) model_push({2'b00, d});
    endtask

    // Call right after send(): checks line levels and busy length of the frame
    task automatic tx_frame_check(input logic [7:0] d, input bit pulse_busy);
        logic bits [NBITS];
        int   n = 0;
        int   k = 0;
        int   bad_idle = 0;
        bits[n++] = 1'b0;
        for (int i = 0; i < DB; i++) bits[n++] = d[i];
        if (PAR != 0) bits[n++] = par_bit(d);
        for (int i = 0; i < SB; i++) bits[n++] = 1'b1;
        while (!tx_rdy && k < NBITS * CLKS + 50) begin
            if (k / CLKS < NBITS && (k % CLKS == 0 || k % CLKS == CLKS - 1))
                check("txd_bit", txd, loopback ? 1'b1 : bits[k / CLKS]);
            if (pulse_busy && k == 45) begin
                tx_vld  = 1'b1;
                tx_data = ~d;
            end else begin
                tx_vld = 1'b0;
            end
            tick(1);
            k++;
        end
        tx_vld = 1'b0;
        check("tx_busy_cycles", k, NBITS * CLKS);
        if (pulse_busy) begin
            for (int i = 0; i < 20; i++) begin
                if (!txd || !tx_rdy) bad_idle++;
                tick(1);
            end
            check("tx_busy_vld_ignored", bad_idle, 0);
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input bit bad_par, input bit stop, input int hold);
        logic bits [NBITS];
        int   n = 0;
        bits[n++] = 1'b0;
        for (int i = 0; i < DB; i++) bits[n++] = d[i];
        if (PAR != 0) bits[n++] = par_bit(d) ^ bad_par;
        bits[n++] = stop;
        model_push({bad_par && (PAR != 0), ~stop, d});
        for (int b = 0; b < n; b++) begin
            rxd_drv = bits[b];
            tick(CLKS);
        end
        if (!stop) tick(hold);
        rxd_drv = 1'b1;
        tick(CLKS);
    endtask

    task automatic wait_drained();
        int t = 0;
        while ((exp_q.size() != 0 || !rx_empty) && t < 400) begin
            tick(1);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=done");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        #1;
        do_reset();

        // Internal loopback, fixed and random bytes
        loopback = 1'b1;
        send(8'hA5, 1);
        tx_frame_check(8'hA5, 0);
        wait_drained();
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            send(r, 1);
            tx_frame_check(r, 0);
            wait_drained();
        end

        // Pin output checked, busy pulses ignored, looped back externally
        loopback = 1'b0;
        ext_loop = 1'b1;
        send(8'h03, 1);
        tx_frame_check(8'h03, 1);
        wait_drained();
        r = 8'($urandom);
        send(r, 1);
        tx_frame_check(r, 1);
        wait_drained();
        ext_loop = 1'b0;
        tick(20);

        // External frames: bad parity, then framing error with long break
        rx_frame(8'h55, 1, 1, 0);
        wait_drained();
        rx_frame(8'h0F, 0, 0, 300);
        wait_drained();
        tick(50);
        check("break_single_word", rx_empty, 1);
        rx_frame(8'($urandom), 1'($urandom), 1, 0);
        wait_drained();

        // Short glitch must not start a frame
        rxd_drv = 1'b0;
        tick(3);
        rxd_drv = 1'b1;
        tick(30);
        check("glitch_no_word", rx_empty, 1);
        rx_frame(8'h3C, 0, 1, 0);
        wait_drained();

        // Overflow: five words into a four-deep FIFO with no reads
        do_reset();
        loopback   = 1'b1;
        auto_drain = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1);
        tick(NBITS * CLKS + 30);
        check("ovf_count", rx_count, exp_q.size());
        check("ovf_flag", rx_overflow, exp_ovf);
        auto_drain = 1'b1;
        wait_drained();

        // Pop in the same cycle as the fifth push keeps count and no overflow
        do_reset();
        auto_drain = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1);
        send(8'h05, 0);
        tick(3 + CLKS / 2 + (NBITS - SB) * CLKS - 1);
        check("pop_at_push_head", rx_data, {24'd0, exp_q.pop_front()});
        man_rd = 1'b1;
        tick(1);
        man_rd = 1'b0;
        model_push({2'b00, 8'h05});
        check("pushpop_full_count", rx_count, exp_q.size());
        check("pushpop_full_ovf", rx_overflow, exp_ovf);
        auto_drain = 1'b1;
        wait_drained();

        // Reset in the middle of a frame on both paths
        loopback = 1'b0;
        ext_loop = 1'b1;
        send(8'h11, 0);
        tick(60);
        do_reset();
        tick(CLKS);
        ext_loop = 1'b0;
        loopback = 1'b1;
        send(8'h7E, 1);
        wait_drained();
        tick(50);
        check("final_empty", rx_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
